id_stage: RTL

//  Decode stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch.

---
 rtl/id_stage_if.sv | 26 ++
 rtl/id_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_if.sv
// Pipeline handshake around the decode stage: IF->ID request, ID->EX request and the IF redirect.
// The decode stage binds the slave modport; the surrounding pipeline (or a bench) binds master.
interface id_stage_if #(
  parameter int IF_ID_W = 64,
  parameter int BJ_W    = 33,
  parameter int ID_EX_W = 145
);
  logic               if_to_id_valid;
  logic [IF_ID_W-1:0] if_to_id_bus;
  logic               id_allowin;
  logic               id_valid;
  logic [BJ_W-1:0]    bj_bus;
  logic               ex_allowin;
  logic               id_to_ex_valid;
  logic [ID_EX_W-1:0] id_to_ex_bus;

  modport slave (
    input  if_to_id_valid, if_to_id_bus, ex_allowin,
    output id_allowin, id_valid, bj_bus, id_to_ex_valid, id_to_ex_bus
  );

  modport master (
    output if_to_id_valid, if_to_id_bus, ex_allowin,
    input  id_allowin, id_valid, bj_bus, id_to_ex_valid, id_to_ex_bus
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: IF->ID register, 32x32 register file, decode, EX/MEM/WB forwarding
// with load-use stall, and branch/jump resolution returning a redirect to fetch.
module id_stage #(
  parameter int FWD_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_if.slave        pipe,
  input  logic [FWD_W-1:0] es_fwd,
  input  logic [FWD_W-1:0] ms_fwd,
  input  logic [FWD_W-1:0] ws_fwd,
  input  logic             ws_rf_we,
  input  logic [4:0]       ws_rf_waddr,
  input  logic [31:0]      ws_rf_wdata
);

  typedef struct packed {
    logic        valid;
    logic        rf_we;
    logic [4:0]  dest;
    logic        data_ok;
    logic [31:0] data;
  } fwd_t;

  typedef struct packed {
    logic        pending;
    logic [31:0] value;
  } src_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
  } alu_op_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        ready_go;

  assign pipe.id_allowin     = !valid | (ready_go & pipe.ex_allowin);
  assign pipe.id_valid       = valid;
  assign pipe.id_to_ex_valid = valid & ready_go;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else if (pipe.id_allowin) begin
      valid <= pipe.if_to_id_valid;
      if (pipe.if_to_id_valid) {inst, pc} <= pipe.if_to_id_bus;
    end
  end

  logic [31:0] rf [32];

  // NOTE: the register file is reset on purpose; it is small and the reset image must be all-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (ws_rf_we && ws_rf_waddr != 5'd0) begin
      rf[ws_rf_waddr] <= ws_rf_wdata;
    end
  end

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'd0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // The WB write is bypassed so a same-cycle read sees the value being written.
  logic [31:0] rf_rs1, rf_rs2;
  assign rf_rs1 = (rs1 == 5'd0) ? 32'd0 :
                  (ws_rf_we && ws_rf_waddr == rs1) ? ws_rf_wdata : rf[rs1];
  assign rf_rs2 = (rs2 == 5'd0) ? 32'd0 :
                  (ws_rf_we && ws_rf_waddr == rs2) ? ws_rf_wdata : rf[rs2];

  function automatic logic hit(input fwd_t f, input logic [4:0] a);
    return f.valid && f.rf_we && f.dest == a && a != 5'd0;
  endfunction

  function automatic src_t resolve(input logic [4:0] a, input fwd_t e, input fwd_t m,
                                   input fwd_t w, input logic [31:0] rf_val);
    if (hit(e, a)) return {!e.data_ok, e.data};
    if (hit(m, a)) return {!m.data_ok, m.data};
    if (hit(w, a)) return {!w.data_ok, w.data};
    return {1'b0, rf_val};
  endfunction

  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  src_t src1, src2;
  assign src1 = resolve(rs1, fwd_t'(es_fwd), fwd_t'(ms_fwd), fwd_t'(ws_fwd), rf_rs1);
  assign src2 = resolve(rs2, fwd_t'(es_fwd), fwd_t'(ms_fwd), fwd_t'(ws_fwd), rf_rs2);

  alu_op_e     alu_op;
  logic [31:0] imm;
  logic        src1_is_pc, src2_is_imm, mem_re, mem_we, mem_unsigned, writes_rd;
  logic [1:0]  mem_size;
  logic        use_rs1, use_rs2, is_jal, is_jalr, is_branch;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    alu_op       = ALU_ADD;
    imm          = 32'd0;
    src1_is_pc   = 1'b0;
    src2_is_imm  = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_size     = 2'd0;
    mem_unsigned = 1'b0;
    writes_rd    = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    is_jal       = 1'b0;
    is_jalr      = 1'b0;
    is_branch    = 1'b0;
    case (opcode)
      OP_LUI:    begin alu_op = ALU_LUI; imm = imm_u; src2_is_imm = 1'b1; writes_rd = 1'b1; end
      OP_AUIPC:  begin imm = imm_u; src1_is_pc = 1'b1; src2_is_imm = 1'b1; writes_rd = 1'b1; end
      // Jumps compute the link address pc+4 in the ALU.
      OP_JAL:    begin imm = 32'd4; src1_is_pc = 1'b1; src2_is_imm = 1'b1; writes_rd = 1'b1;
                       is_jal = 1'b1; end
      OP_JALR:   begin imm = 32'd4; src1_is_pc = 1'b1; src2_is_imm = 1'b1; writes_rd = 1'b1;
                       is_jalr = 1'b1; use_rs1 = 1'b1; end
      OP_BRANCH: begin imm = imm_b; is_branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LOAD:   begin imm = imm_i; src2_is_imm = 1'b1; mem_re = 1'b1; mem_size = funct3[1:0];
                       mem_unsigned = funct3[2]; writes_rd = 1'b1; use_rs1 = 1'b1; end
      OP_STORE:  begin imm = imm_s; src2_is_imm = 1'b1; mem_we = 1'b1; mem_size = funct3[1:0];
                       use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM:    begin imm = imm_i; src2_is_imm = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1;
                       alu_op = alu_from_funct3(funct3, inst[30], 1'b0); end
      OP_REG:    begin writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                       alu_op = alu_from_funct3(funct3, inst[30], 1'b1); end
      default:   ;
    endcase
  end

  logic br_taken;
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = src1.value == src2.value;
      3'b001:  br_taken = src1.value != src2.value;
      3'b100:  br_taken = $signed(src1.value) <  $signed(src2.value);
      3'b101:  br_taken = $signed(src1.value) >= $signed(src2.value);
      3'b110:  br_taken = src1.value <  src2.value;
      3'b111:  br_taken = src1.value >= src2.value;
      default: br_taken = 1'b0;
    endcase
  end

  assign ready_go = !(use_rs1 && src1.pending) && !(use_rs2 && src2.pending);

  logic        rf_we, bj_wen;
  logic [4:0]  dest;
  logic [31:0] bj_target;

  assign rf_we     = writes_rd && rd != 5'd0;
  assign dest      = rf_we ? rd : 5'd0;
  assign bj_wen    = valid && ready_go && (is_jal || is_jalr || (is_branch && br_taken));
  assign bj_target = is_jalr ? ((src1.value + imm_i) & ~32'd1) : pc + (is_jal ? imm_j : imm_b);
  assign pipe.bj_bus = {bj_wen, bj_wen ? bj_target : 32'd0};

  assign pipe.id_to_ex_bus = {pc, src1.value, src2.value, imm, alu_op, src1_is_pc, src2_is_imm,
                              mem_re, mem_we, mem_size, mem_unsigned, rf_we, dest};

endmodule
